// File: rtl/ethmac_bd_ram_arb.sv
// ethmac_bd_ram_arb
// Arbiter and sequencer in front of the single-port, byte-writable
// buffer-descriptor RAM. Two hold-until-ack requesters (host bus slave and
// MAC descriptor engine) share the RAM. Each access runs IDLE -> ACCESS ->
// RESP, so a request seen in IDLE is acked two cycles later, and at most one
// access completes every three cycles.
//
// Ports
//   Clk, Reset          clock, synchronous active-high reset
//   host_* / eng_*      request groups: req, we, sel (byte enables), adr,
//                       dat_i in; ack (one-cycle pulse) and dat_o out
//   ram_cen, ram_wen    active-low chip enable / per-byte write enable
//   ram_oen             active-low output enable, tied low
//   ram_adr, ram_di     RAM address / write data
//   ram_dout            RAM read data, registered inside the RAM
//
// Parameters
//   AW, DW              address width, data width (multiple of 8)
//   ARB_MODE            0 = round-robin, 1 = engine priority with host
//                       anti-starvation
//   MAXWAIT             ARB_MODE=1: engine grants in a row, while the host
//                       waits, before the host is forced to win (1..15)
module ethmac_bd_ram_arb #(
    parameter int AW       = 8,
    parameter int DW       = 32,
    parameter int ARB_MODE = 0,
    parameter int MAXWAIT  = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [DW/8-1:0]   host_sel,
    input  logic [AW-1:0]     host_adr,
    input  logic [DW-1:0]     host_dat_i,
    output logic              host_ack,
    output logic [DW-1:0]     host_dat_o,
    input  logic              eng_req,
    input  logic              eng_we,
    input  logic [DW/8-1:0]   eng_sel,
    input  logic [AW-1:0]     eng_adr,
    input  logic [DW-1:0]     eng_dat_i,
    output logic              eng_ack,
    output logic [DW-1:0]     eng_dat_o,
    output logic              ram_cen,
    output logic [DW/8-1:0]   ram_wen,
    output logic              ram_oen,
    output logic [AW-1:0]     ram_adr,
    output logic [DW-1:0]     ram_di,
    input  logic [DW-1:0]     ram_dout
);

    localparam int NB = DW / 8;

    localparam logic       G_HOST = 1'b0;
    localparam logic       G_ENG  = 1'b1;
    localparam logic [3:0] MAXW   = 4'(MAXWAIT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            grant_q, grant_d;          // requester owning the current access
    logic            last_grant_q, last_grant_d;
    logic [3:0]      starve_q, starve_d;        // engine grants while host waits
    logic            host_ack_q, host_ack_d;
    logic            eng_ack_q, eng_ack_d;
    logic            ram_cen_q, ram_cen_d;
    logic [NB-1:0]   ram_wen_q, ram_wen_d;
    logic [AW-1:0]   ram_adr_q, ram_adr_d;
    logic [DW-1:0]   ram_di_q, ram_di_d;
    logic            pick_eng_s;

    // Arbitration decision for a request seen in IDLE.
    always_comb begin
        pick_eng_s = 1'b0;
        if (host_req && eng_req) begin
            if (ARB_MODE == 0) begin
                pick_eng_s = (last_grant_q == G_HOST);
            end else begin
                pick_eng_s = (starve_q != MAXW);
            end
        end else begin
            pick_eng_s = eng_req;
        end
    end

    // Next-state logic; RAM controls are computed one cycle ahead so they are
    // driven straight from flops during ACCESS.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        starve_d     = starve_q;
        host_ack_d   = 1'b0;
        eng_ack_d    = 1'b0;
        ram_cen_d    = 1'b1;
        ram_wen_d    = {NB{1'b1}};
        ram_adr_d    = ram_adr_q;
        ram_di_d     = ram_di_q;
        case (state_q)
            S_IDLE: begin
                if (host_req || eng_req) begin
                    state_d   = S_ACCESS;
                    grant_d   = pick_eng_s;
                    ram_cen_d = 1'b0;
                    if (pick_eng_s) begin
                        ram_adr_d = eng_adr;
                        ram_di_d  = eng_dat_i;
                        ram_wen_d = eng_we ? ~eng_sel : {NB{1'b1}};
                    end else begin
                        ram_adr_d = host_adr;
                        ram_di_d  = host_dat_i;
                        ram_wen_d = host_we ? ~host_sel : {NB{1'b1}};
                    end
                end else begin
                    state_d = S_IDLE;
                end
                // Counter only moves on IDLE decisions; a host grant or an
                // idle host clears it, an engine grant over a waiting host
                // bumps it up to MAXWAIT.
                if (ARB_MODE == 0) begin
                    starve_d = 4'd0;
                end else if (!host_req) begin
                    starve_d = 4'd0;
                end else if (!pick_eng_s) begin
                    starve_d = 4'd0;
                end else if (starve_q != MAXW) begin
                    starve_d = starve_q + 4'd1;
                end else begin
                    starve_d = starve_q;
                end
            end
            S_ACCESS: begin
                state_d      = S_RESP;
                last_grant_d = grant_q;
                host_ack_d   = (grant_q == G_HOST);
                eng_ack_d    = (grant_q == G_ENG);
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            grant_q      <= G_HOST;
            last_grant_q <= G_HOST;
            starve_q     <= 4'd0;
            host_ack_q   <= 1'b0;
            eng_ack_q    <= 1'b0;
            ram_cen_q    <= 1'b1;
            ram_wen_q    <= {NB{1'b1}};
            ram_adr_q    <= {AW{1'b0}};
            ram_di_q     <= {DW{1'b0}};
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            starve_q     <= starve_d;
            host_ack_q   <= host_ack_d;
            eng_ack_q    <= eng_ack_d;
            ram_cen_q    <= ram_cen_d;
            ram_wen_q    <= ram_wen_d;
            ram_adr_q    <= ram_adr_d;
            ram_di_q     <= ram_di_d;
        end
    end

    assign host_ack = host_ack_q;
    assign eng_ack  = eng_ack_q;
    assign ram_cen  = ram_cen_q;
    assign ram_wen  = ram_wen_q;
    assign ram_adr  = ram_adr_q;
    assign ram_di   = ram_di_q;
    assign ram_oen  = 1'b0;

    // The RAM already registers its output, so read data is passed through;
    // it is only meaningful in the RESP cycle while ack is high.
    assign host_dat_o = ram_dout;
    assign eng_dat_o  = ram_dout;

endmodule

// File: tb/tb_ethmac_bd_ram_arb.sv
module tb_ethmac_bd_ram_arb;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        who;   // 0 = host, 1 = engine
        logic        chk;   // compare read data
        logic [31:0] data;
    } exp_t;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    // DUT A: round-robin, with RAM model
    logic        host_req_a = 1'b0, host_we_a = 1'b0, eng_req_a = 1'b0, eng_we_a = 1'b0;
    logic [3:0]  host_sel_a = 4'h0, eng_sel_a = 4'h0;
    logic [7:0]  host_adr_a = 8'h00, eng_adr_a = 8'h00;
    logic [31:0] host_dat_i_a = 32'h0, eng_dat_i_a = 32'h0;
    logic        host_ack_a, eng_ack_a, ram_cen_a, ram_oen_a;
    logic [31:0] host_dat_o_a, eng_dat_o_a, ram_di_a;
    logic [3:0]  ram_wen_a;
    logic [7:0]  ram_adr_a;
    logic [31:0] ram_dout_a;

    // DUT B: engine priority, MAXWAIT=4, RAM output tied to zero
    logic        host_req_b = 1'b0, eng_req_b = 1'b0;
    logic        host_we_b = 1'b0, eng_we_b = 1'b0;
    logic [3:0]  host_sel_b = 4'hF, eng_sel_b = 4'hF;
    logic [7:0]  host_adr_b = 8'h01, eng_adr_b = 8'h02;
    logic [31:0] host_dat_i_b = 32'h0, eng_dat_i_b = 32'h0;
    logic        host_ack_b, eng_ack_b, ram_cen_b, ram_oen_b;
    logic [31:0] host_dat_o_b, eng_dat_o_b, ram_di_b;
    logic [3:0]  ram_wen_b;
    logic [7:0]  ram_adr_b;
    logic [31:0] ram_dout_b = 32'h0;

    logic [31:0] mem_a  [0:255];
    logic [31:0] shadow [0:255];

    ethmac_bd_ram_arb #(.AW(8), .DW(32), .ARB_MODE(0), .MAXWAIT(4)) dut_a (
        .Clk(Clk), .Reset(Reset),
        .host_req(host_req_a), .host_we(host_we_a), .host_sel(host_sel_a),
        .host_adr(host_adr_a), .host_dat_i(host_dat_i_a),
        .host_ack(host_ack_a), .host_dat_o(host_dat_o_a),
        .eng_req(eng_req_a), .eng_we(eng_we_a), .eng_sel(eng_sel_a),
        .eng_adr(eng_adr_a), .eng_dat_i(eng_dat_i_a),
        .eng_ack(eng_ack_a), .eng_dat_o(eng_dat_o_a),
        .ram_cen(ram_cen_a), .ram_wen(ram_wen_a), .ram_oen(ram_oen_a),
        .ram_adr(ram_adr_a), .ram_di(ram_di_a), .ram_dout(ram_dout_a)
    );

    ethmac_bd_ram_arb #(.AW(8), .DW(32), .ARB_MODE(1), .MAXWAIT(4)) dut_b (
        .Clk(Clk), .Reset(Reset),
        .host_req(host_req_b), .host_we(host_we_b), .host_sel(host_sel_b),
        .host_adr(host_adr_b), .host_dat_i(host_dat_i_b),
        .host_ack(host_ack_b), .host_dat_o(host_dat_o_b),
        .eng_req(eng_req_b), .eng_we(eng_we_b), .eng_sel(eng_sel_b),
        .eng_adr(eng_adr_b), .eng_dat_i(eng_dat_i_b),
        .eng_ack(eng_ack_b), .eng_dat_o(eng_dat_o_b),
        .ram_cen(ram_cen_b), .ram_wen(ram_wen_b), .ram_oen(ram_oen_b),
        .ram_adr(ram_adr_b), .ram_di(ram_di_b), .ram_dout(ram_dout_b)
    );

    // Byte-writable RAM with registered read data
    always @(posedge Clk) begin
        if (!ram_cen_a) begin
            ram_dout_a <= mem_a[ram_adr_a];
            for (int b = 0; b < 4; b++) begin
                if (!ram_wen_a[b]) mem_a[ram_adr_a][8*b +: 8] <= ram_di_a[8*b +: 8];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard for DUT A
    always @(negedge Clk) begin
        if (host_ack_a || eng_ack_a) begin
            check_eq("a_ack_onehot", {63'd0, host_ack_a & eng_ack_a}, 64'd0);
            if (qa.size() == 0) begin
                check_eq("a_unexpected_ack", {62'd0, host_ack_a, eng_ack_a}, 64'd0);
            end else begin
                ea = qa.pop_front();
                check_eq("a_ack_who", {63'd0, eng_ack_a}, {63'd0, ea.who});
                if (ea.chk)
                    check_eq("a_rd_data", eng_ack_a ? eng_dat_o_a : host_dat_o_a, {32'd0, ea.data});
            end
        end
    end

    // Scoreboard for DUT B
    always @(negedge Clk) begin
        if (host_ack_b || eng_ack_b) begin
            check_eq("b_ack_onehot", {63'd0, host_ack_b & eng_ack_b}, 64'd0);
            if (qb.size() == 0) begin
                check_eq("b_unexpected_ack", {62'd0, host_ack_b, eng_ack_b}, 64'd0);
            end else begin
                eb = qb.pop_front();
                check_eq("b_ack_who", {63'd0, eng_ack_b}, {63'd0, eb.who});
                if (eb.chk)
                    check_eq("b_rd_data", eng_ack_b ? eng_dat_o_b : host_dat_o_b, {32'd0, eb.data});
            end
        end
    end

    task automatic pulse_reset();
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
    endtask

    // One single access on DUT A, with cycle-accurate checks of the RAM cycle
    task automatic do_op(input logic who, input logic we, input logic [3:0] sel,
                         input logic [7:0] adr, input logic [31:0] dat);
        exp_t        e;
        logic [3:0]  exp_wen;
        logic [31:0] nv;
        @(posedge Clk); #1;
        exp_wen = we ? ~sel : 4'hF;
        if (who) begin
            eng_req_a = 1'b1; eng_we_a = we; eng_sel_a = sel; eng_adr_a = adr; eng_dat_i_a = dat;
        end else begin
            host_req_a = 1'b1; host_we_a = we; host_sel_a = sel; host_adr_a = adr; host_dat_i_a = dat;
        end
        e.who = who; e.chk = ~we; e.data = shadow[adr];
        qa.push_back(e);
        if (we) begin
            nv = shadow[adr];
            for (int b = 0; b < 4; b++) if (sel[b]) nv[8*b +: 8] = dat[8*b +: 8];
            shadow[adr] = nv;
        end
        check_eq("idle_cen", {63'd0, ram_cen_a}, 64'd1);
        @(posedge Clk); #1;
        check_eq("acc_cen", {63'd0, ram_cen_a}, 64'd0);
        check_eq("acc_wen", {60'd0, ram_wen_a}, {60'd0, exp_wen});
        check_eq("acc_adr", {56'd0, ram_adr_a}, {56'd0, adr});
        if (we) check_eq("acc_di", {32'd0, ram_di_a}, {32'd0, dat});
        check_eq("acc_noack", {63'd0, host_ack_a | eng_ack_a}, 64'd0);
        @(posedge Clk); #1;
        check_eq("resp_ack", {63'd0, who ? eng_ack_a : host_ack_a}, 64'd1);
        check_eq("resp_other_ack", {63'd0, who ? host_ack_a : eng_ack_a}, 64'd0);
        check_eq("resp_cen", {63'd0, ram_cen_a}, 64'd1);
        host_req_a = 1'b0;
        eng_req_a  = 1'b0;
        @(posedge Clk); #1;
        check_eq("post_ack", {63'd0, host_ack_a | eng_ack_a}, 64'd0);
    endtask

    initial begin
        int acks;
        int last_c;
        exp_t e;
        for (int i = 0; i < 256; i++) begin
            mem_a[i]  = 32'h0;
            shadow[i] = 32'h0;
        end

        // Reset values
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check_eq("rst_host_ack", {63'd0, host_ack_a}, 64'd0);
        check_eq("rst_eng_ack", {63'd0, eng_ack_a}, 64'd0);
        check_eq("rst_cen", {63'd0, ram_cen_a}, 64'd1);
        check_eq("rst_wen", {60'd0, ram_wen_a}, 64'hF);
        check_eq("rst_adr", {56'd0, ram_adr_a}, 64'd0);
        check_eq("rst_di", {32'd0, ram_di_a}, 64'd0);
        check_eq("rst_oen", {63'd0, ram_oen_a}, 64'd0);
        Reset = 1'b0;

        // Host write then read
        do_op(1'b0, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF);
        do_op(1'b0, 1'b0, 4'hF, 8'h10, 32'h0);

        // Byte masking (engine writes, host reads back)
        do_op(1'b1, 1'b1, 4'hF, 8'h20, 32'hAAAAAAAA);
        do_op(1'b1, 1'b1, 4'h5, 8'h20, 32'h11223344);
        do_op(1'b0, 1'b0, 4'hF, 8'h20, 32'h0);

        // Zero-sel write leaves contents alone but is still acked
        do_op(1'b0, 1'b1, 4'hF, 8'h30, 32'h55667788);
        do_op(1'b0, 1'b1, 4'h0, 8'h30, 32'hFFFFFFFF);
        do_op(1'b1, 1'b0, 4'hF, 8'h30, 32'h0);

        // Reset during ACCESS, then read of the top address
        do_op(1'b0, 1'b1, 4'hF, 8'hFF, 32'hCAFEF00D);
        @(posedge Clk); #1;
        host_req_a = 1'b1; host_we_a = 1'b0; host_sel_a = 4'hF; host_adr_a = 8'hFF;
        @(posedge Clk); #1;
        check_eq("mid_acc_cen", {63'd0, ram_cen_a}, 64'd0);
        Reset = 1'b1;
        host_req_a = 1'b0;
        @(posedge Clk); #1;
        check_eq("mid_rst_ack", {62'd0, host_ack_a, eng_ack_a}, 64'd0);
        check_eq("mid_rst_cen", {63'd0, ram_cen_a}, 64'd1);
        check_eq("mid_rst_wen", {60'd0, ram_wen_a}, 64'hF);
        Reset = 1'b0;
        @(posedge Clk); #1;
        check_eq("mid_rst_noack", {62'd0, host_ack_a, eng_ack_a}, 64'd0);
        do_op(1'b0, 1'b0, 4'hF, 8'hFF, 32'h0);

        // Round-robin with both requesting continuously
        pulse_reset();
        @(posedge Clk); #1;
        host_req_a = 1'b1; host_we_a = 1'b0; host_sel_a = 4'hF; host_adr_a = 8'h10;
        eng_req_a  = 1'b1; eng_we_a  = 1'b0; eng_sel_a  = 4'hF; eng_adr_a  = 8'h20;
        for (int k = 0; k < 6; k++) begin
            e.who = (k % 2 == 0) ? 1'b1 : 1'b0;
            e.chk = 1'b1;
            e.data = e.who ? shadow[8'h20] : shadow[8'h10];
            qa.push_back(e);
        end
        acks = 0; last_c = 0;
        for (int c = 0; c < 40 && acks < 6; c++) begin
            @(posedge Clk); #1;
            if (host_ack_a || eng_ack_a) begin
                acks++;
                if (acks == 1) check_eq("rr_first_latency", c, 64'd1);
                else check_eq("rr_ack_spacing", c - last_c, 64'd3);
                last_c = c;
                if (acks == 6) begin
                    host_req_a = 1'b0;
                    eng_req_a  = 1'b0;
                end
            end
        end
        check_eq("rr_ack_count", acks, 64'd6);
        host_req_a = 1'b0;
        eng_req_a  = 1'b0;

        // Anti-starvation on DUT B
        pulse_reset();
        @(posedge Clk); #1;
        host_req_b = 1'b1;
        eng_req_b  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            e.who  = (k % 5 == 4) ? 1'b0 : 1'b1;
            e.chk  = 1'b1;
            e.data = 32'h0;
            qb.push_back(e);
        end
        acks = 0; last_c = 0;
        for (int c = 0; c < 60 && acks < 10; c++) begin
            @(posedge Clk); #1;
            if (host_ack_b || eng_ack_b) begin
                acks++;
                if (acks == 1) check_eq("as_first_latency", c, 64'd1);
                else check_eq("as_ack_spacing", c - last_c, 64'd3);
                last_c = c;
                if (acks == 10) begin
                    host_req_b = 1'b0;
                    eng_req_b  = 1'b0;
                end
            end
        end
        check_eq("as_ack_count", acks, 64'd10);
        host_req_b = 1'b0;
        eng_req_b  = 1'b0;

        repeat (5) @(posedge Clk);
        #1;
        check_eq("a_queue_empty", qa.size(), 64'd0);
        check_eq("b_queue_empty", qb.size(), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
